// File: rtl/rf_stream_ctrl_if.sv
// Bundle of the command, LOAD/DUMP stream and register-file port signals of rf_stream_ctrl.
// master is the controller's view; slave is the host/register-file side.
interface rf_stream_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [CNT_W-1:0]  cmd_count;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    logic [ADDR_W-1:0] rf_dir_a;
    logic [DATA_W-1:0] rf_data_a;
    logic [ADDR_W-1:0] rf_dir_wr;
    logic [DATA_W-1:0] rf_di;
    logic              rf_we;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  in_valid, in_data,
        input  out_ready,
        input  rf_data_a,
        output cmd_ready, in_ready,
        output out_valid, out_data,
        output rf_dir_a, rf_dir_wr, rf_di, rf_we,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output in_valid, in_data,
        output out_ready,
        output rf_data_a,
        input  cmd_ready, in_ready,
        input  out_valid, out_data,
        input  rf_dir_a, rf_dir_wr, rf_di, rf_we,
        input  busy, done
    );
endinterface

// File: rtl/rf_stream_ctrl.sv
// Host-side LOAD/DUMP controller for the 16x32 filter register file.
// Define RF_STREAM_CHECKSUM_EN to append a wrapping-sum beat after every DUMP.
module rf_stream_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_stream_ctrl_if.master   bus_io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_OUT,
`ifdef RF_STREAM_CHECKSUM_EN
        S_DUMP_SUM,
`endif
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_dir_wr_q, rf_dir_wr_d;
    logic [DATA_W-1:0] rf_di_q, rf_di_d;
    logic [ADDR_W-1:0] rf_dir_a_q, rf_dir_a_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
`ifdef RF_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // The read address is loaded one state ahead so it is stable across DUMP_RD.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        rf_we_d     = 1'b0;
        rf_dir_wr_d = rf_dir_wr_q;
        rf_di_d     = rf_di_q;
        rf_dir_a_d  = rf_dir_a_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef RF_STREAM_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_io.cmd_valid) begin
                    addr_d = bus_io.cmd_base;
                    rem_d  = bus_io.cmd_count;
`ifdef RF_STREAM_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (bus_io.cmd_count == '0) begin
                        state_d = S_DONE;
                    end else if (bus_io.cmd_op) begin
                        rf_dir_a_d = bus_io.cmd_base;
                        state_d    = S_DUMP_RD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus_io.in_valid) begin
                    rf_we_d     = 1'b1;
                    rf_dir_wr_d = addr_q;
                    rf_di_d     = bus_io.in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DUMP_RD: begin
                out_data_d  = bus_io.rf_data_a;
                out_valid_d = 1'b1;
`ifdef RF_STREAM_CHECKSUM_EN
                sum_d       = sum_q + bus_io.rf_data_a;
`endif
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_d       = rem_q - CNT_W'(1);
                    rf_dir_a_d  = addr_q + ADDR_W'(1);
                    if (rem_q != CNT_W'(1)) begin
                        state_d = S_DUMP_RD;
                    end else begin
`ifdef RF_STREAM_CHECKSUM_EN
                        out_data_d  = sum_q;
                        out_valid_d = 1'b1;
                        state_d     = S_DUMP_SUM;
`else
                        state_d     = S_DONE;
`endif
                    end
                end
            end
`ifdef RF_STREAM_CHECKSUM_EN
            S_DUMP_SUM: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_dir_wr_q <= '0;
            rf_di_q     <= '0;
            rf_dir_a_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef RF_STREAM_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            rf_we_q     <= rf_we_d;
            rf_dir_wr_q <= rf_dir_wr_d;
            rf_di_q     <= rf_di_d;
            rf_dir_a_q  <= rf_dir_a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef RF_STREAM_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Handshake readies and status are decoded from the state, so reset forces them at once.
    assign bus_io.cmd_ready = (state_q == S_IDLE);
    assign bus_io.in_ready  = (state_q == S_LOAD);
    assign bus_io.busy      = (state_q != S_IDLE);
    assign bus_io.done      = (state_q == S_DONE);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.rf_dir_a  = rf_dir_a_q;
    assign bus_io.rf_dir_wr = rf_dir_wr_q;
    assign bus_io.rf_di     = rf_di_q;
    assign bus_io.rf_we     = rf_we_q;

endmodule

// File: tb/tb_rf_stream_ctrl.sv
// Bench for rf_stream_ctrl: vector table, randomized commands against a register-file
// model, and a mid-LOAD reset sequence. Define RF_STREAM_CHECKSUM_EN to cover the sum beat.
`timescale 1ns/1ps
module tb_rf_stream_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 16;
`ifdef RF_STREAM_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    always #5 clk = ~clk;

    rf_stream_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    rf_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Register file fixture: combinational read port A, write committed on negedge.
    logic [31:0] rfMem [DEPTH];
    logic [31:0] model [DEPTH];
    assign bus.rf_data_a = rfMem[bus.rf_dir_a];
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) rfMem[i] <= 32'hA5A50000 + 32'(i) * 32'h101;
        end else if (bus.rf_we) begin
            rfMem[bus.rf_dir_wr] <= bus.rf_di;
        end
    end

    typedef struct {
        logic        op;
        logic [3:0]  base;
        logic [4:0]  count;
        logic [31:0] dStart;
        logic [31:0] dStep;
        int          gap;
        int          stallBeat;
        int          stallCycles;
        bit          rndReady;
        bit          poke;
        int          expWrites;
        int          expBeats;
        logic [31:0] expFirst;
    } vecT;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wrT;

    int          nVec = 0;
    int          nMis = 0;
    logic [31:0] lastBeat;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vecT mkVec(input logic op, input logic [3:0] base, input logic [4:0] count,
                                  input logic [31:0] dStart, input logic [31:0] dStep, input int gap,
                                  input int stallBeat, input int stallCycles, input bit rndReady,
                                  input bit poke, input int expWrites, input int expBeats,
                                  input logic [31:0] expFirst);
        vecT v;
        v.op = op; v.base = base; v.count = count; v.dStart = dStart; v.dStep = dStep;
        v.gap = gap; v.stallBeat = stallBeat; v.stallCycles = stallCycles;
        v.rndReady = rndReady; v.poke = poke;
        v.expWrites = expWrites; v.expBeats = expBeats; v.expFirst = expFirst;
        return v;
    endfunction

    task automatic issueCmd(input logic op, input logic [3:0] base, input logic [4:0] count);
        bit acc = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = count;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk); #1;
        end
        checkOutput("cmd accepted", 32'(acc), 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    // Runs one command, checking every write and beat against queues built from the model.
    task automatic applyStimulus(input vecT v);
        wrT          wrQ[$];
        logic [31:0] beatQ[$];
        logic [31:0] sum = '0;
        logic [31:0] firstSeen = '0;
        logic [31:0] heldData = '0;
        wrT          w;
        bit          held = 1'b0;
        bit          iv;
        int          a;
        int          wordIdx = 0, beatIdx = 0, stallCnt = 0;
        int          nWr = 0, nBeat = 0, doneCyc = -1;
        int          budget = 30 + 12 * (int'(v.count) + 1);

        for (int i = 0; i < int'(v.count); i++) begin
            a = (int'(v.base) + i) % DEPTH;
            if (!v.op) begin
                wrQ.push_back({4'(a), v.dStart + 32'(i) * v.dStep});
                model[a] = v.dStart + 32'(i) * v.dStep;
            end else begin
                beatQ.push_back(model[a]);
                sum += model[a];
            end
        end
        if (CK != 0 && v.op && v.count != 0) beatQ.push_back(sum);

        issueCmd(v.op, v.base, v.count);
        if (v.poke) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_base = 4'd0; bus.cmd_count = 5'd1;
        end

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (!v.op) begin
                case (v.gap)
                    0:       iv = 1'b1;
                    1:       iv = (cyc % 2 == 0);
                    default: iv = ($urandom % 2) == 1;
                endcase
                bus.in_valid  = iv && (wordIdx < int'(v.count));
                bus.in_data   = v.dStart + 32'(wordIdx) * v.dStep;
                bus.out_ready = ($urandom % 2) == 1;
            end else begin
                bus.in_valid = ($urandom % 2) == 1;
                bus.in_data  = $urandom;
                if (v.rndReady) bus.out_ready = ($urandom % 2) == 1;
                else            bus.out_ready = !(beatIdx == v.stallBeat && stallCnt < v.stallCycles);
            end

            @(negedge clk);
            if (v.poke) checkOutput("cmd_ready while busy", 32'(bus.cmd_ready), 32'd0);
            if (held) begin
                checkOutput("stalled out_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("stalled out_data", bus.out_data, heldData);
            end
            held = 1'b0;
            if (bus.rf_we) begin
                checkOutput("write expected", 32'(wrQ.size() != 0), 32'd1);
                if (wrQ.size() != 0) begin
                    w = wrQ.pop_front();
                    checkOutput("rf_dir_wr", 32'(bus.rf_dir_wr), 32'(w.a));
                    checkOutput("rf_di", bus.rf_di, w.d);
                end
                if (nWr == 0) firstSeen = bus.rf_di;
                nWr++;
            end
            if (bus.in_valid && bus.in_ready) wordIdx++;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    checkOutput("beat expected", 32'(beatQ.size() != 0), 32'd1);
                    if (beatQ.size() != 0) checkOutput("out_data", bus.out_data, beatQ.pop_front());
                    if (nBeat == 0) firstSeen = bus.out_data;
                    lastBeat = bus.out_data;
                    nBeat++;
                    beatIdx++;
                end else begin
                    held = 1'b1;
                    heldData = bus.out_data;
                    if (beatIdx == v.stallBeat) stallCnt++;
                end
            end
            if (bus.done) begin
                doneCyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end

        checkOutput("done seen", 32'(doneCyc >= 0), 32'd1);
        if (v.count == 0) checkOutput("count0 done latency", 32'(doneCyc), 32'd0);
        checkOutput("write count", 32'(nWr), 32'(v.expWrites));
        checkOutput("beat count", 32'(nBeat), 32'(v.expBeats));
        if (v.count != 0) checkOutput("first word", firstSeen, v.expFirst);
        checkOutput("writes left", 32'(wrQ.size()), 32'd0);
        checkOutput("beats left", 32'(beatQ.size()), 32'd0);

        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("done pulse width", 32'(bus.done), 32'd0);
        checkOutput("idle busy", 32'(bus.busy), 32'd0);
        checkOutput("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("idle in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("idle out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle rf_we", 32'(bus.rf_we), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecT tbl[10];
        vecT rv;
        logic [31:0] exp5, exp6;
        int wordIdx, nWr;

        rst_n = 1'b0; preload = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'hA5A50000 + 32'(i) * 32'h101;

        tbl[0] = mkVec(1'b0, 4'd3,  5'd3,  32'h11,       32'h11, 1, -1, 0, 1'b0, 1'b0, 3, 0,      32'h11);
        tbl[1] = mkVec(1'b1, 4'd3,  5'd3,  32'h0,        32'h0,  0,  1, 3, 1'b0, 1'b0, 0, 3 + CK, 32'h11);
        tbl[2] = mkVec(1'b0, 4'd14, 5'd4,  32'hA,        32'h1,  0, -1, 0, 1'b0, 1'b0, 4, 0,      32'hA);
        tbl[3] = mkVec(1'b1, 4'd14, 5'd4,  32'h0,        32'h0,  0, -1, 0, 1'b0, 1'b1, 0, 4 + CK, 32'hA);
        tbl[4] = mkVec(1'b0, 4'd5,  5'd0,  32'h77,       32'h1,  0, -1, 0, 1'b0, 1'b0, 0, 0,      32'h0);
        tbl[5] = mkVec(1'b1, 4'd9,  5'd0,  32'h0,        32'h0,  0, -1, 0, 1'b0, 1'b0, 0, 0,      32'h0);
        tbl[6] = mkVec(1'b0, 4'd8,  5'd2,  32'hFFFFFFFF, 32'h3,  0, -1, 0, 1'b0, 1'b0, 2, 0,      32'hFFFFFFFF);
        tbl[7] = mkVec(1'b1, 4'd8,  5'd2,  32'h0,        32'h0,  0, -1, 0, 1'b0, 1'b0, 0, 2 + CK, 32'hFFFFFFFF);
        tbl[8] = mkVec(1'b1, 4'd0,  5'd18, 32'h0,        32'h0,  0, -1, 0, 1'b1, 1'b0, 0, 18 + CK, 32'hC);
        tbl[9] = mkVec(1'b0, 4'd15, 5'd17, 32'h100,      32'h10, 2, -1, 0, 1'b0, 1'b0, 17, 0,     32'h100);

        @(negedge clk); @(negedge clk);
        checkOutput("reset rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset rf_dir_a", 32'(bus.rf_dir_a), 32'd0);
        checkOutput("reset rf_dir_wr", 32'(bus.rf_dir_wr), 32'd0);
        checkOutput("reset rf_di", bus.rf_di, 32'd0);
        checkOutput("reset out_data", bus.out_data, 32'd0);
        preload = 1'b0;
        #2 rst_n = 1'b1;

        $display("[TB] vector table");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(tbl[k]);
`ifdef RF_STREAM_CHECKSUM_EN
            if (k == 7) checkOutput("checksum beat", lastBeat, 32'h1);
`endif
        end

        $display("[TB] randomized commands");
        for (int k = 0; k < 40; k++) begin
            rv.op          = ($urandom % 2) == 1;
            rv.base        = 4'($urandom_range(0, 15));
            rv.count       = 5'($urandom_range(0, 20));
            rv.dStart      = $urandom;
            rv.dStep       = $urandom;
            rv.gap         = 2;
            rv.stallBeat   = -1;
            rv.stallCycles = 0;
            rv.rndReady    = 1'b1;
            rv.poke        = 1'b0;
            rv.expWrites   = rv.op ? 0 : int'(rv.count);
            rv.expBeats    = rv.op ? int'(rv.count) + ((rv.count != 0) ? CK : 0) : 0;
            rv.expFirst    = rv.op ? model[rv.base] : rv.dStart;
            applyStimulus(rv);
        end

        $display("[TB] reset during LOAD");
        exp5 = model[5];
        exp6 = model[6];
        issueCmd(1'b0, 4'd3, 5'd4);
        wordIdx = 0;
        nWr = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC0DE0000 + 32'(wordIdx);
            @(negedge clk);
            if (bus.rf_we) nWr++;
            if (bus.in_valid && bus.in_ready) wordIdx++;
            if (nWr == 2) break;
            @(posedge clk); #1;
        end
        checkOutput("writes before reset", 32'(nWr), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("async reset busy", 32'(bus.busy), 32'd0);
        checkOutput("async reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("async reset in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("async reset done", 32'(bus.done), 32'd0);
        checkOutput("async reset rf_dir_wr", 32'(bus.rf_dir_wr), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checkOutput("reg3 after reset", rfMem[3], 32'hC0DE0000);
        checkOutput("reg4 after reset", rfMem[4], 32'hC0DE0001);
        checkOutput("reg5 untouched", rfMem[5], exp5);
        checkOutput("reg6 untouched", rfMem[6], exp6);
        model[3] = 32'hC0DE0000;
        model[4] = 32'hC0DE0001;
        #2 rst_n = 1'b1;
        applyStimulus(mkVec(1'b1, 4'd3, 5'd4, 32'h0, 32'h0, 0, -1, 0, 1'b1, 1'b0, 0, 4 + CK, 32'hC0DE0000));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule

// File: doc/rf_stream_ctrl.md
Name: rf_stream_ctrl

Overview:
- Initiator-side controller for the 16x32 filter-processor register file.
- Takes a command (LOAD or DUMP, base register, word count) and moves that many words:
  - LOAD: from a valid/ready input stream into the register file write port.
  - DUMP: from the register file read port A onto a valid/ready output stream.
- Used by the host/debug path to preload filter coefficients and read back results without the datapath.

Parameters:
- ADDR_W, 4, register address width; register file depth = 2**ADDR_W.
- DATA_W, 32, data word width.
- CNT_W, 5, command count width; must hold the value 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  1  0 = LOAD, 1 = DUMP.
- cmd_base  in  ADDR_W  first register address.
- cmd_count  in  CNT_W  number of words; 0 = no-op.
- in_valid / in_ready  in/out  1  LOAD data handshake.
- in_data  in  DATA_W  LOAD data word.
- out_valid / out_ready  out/in  1  DUMP data handshake.
- out_data  out  DATA_W  DUMP data word.
- rf_dir_a  out  ADDR_W  register file read address A.
- rf_data_a  in  DATA_W  register file read data A (combinational from rf_dir_a).
- rf_dir_wr  out  ADDR_W  register file write address.
- rf_di  out  DATA_W  register file write data.
- rf_we  out  1  register file write enable (file writes on negedge clk).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command completion.

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - state = IDLE.
  - rf_we, out_valid, done, busy = 0.
  - rf_dir_a, rf_dir_wr, rf_di, out_data = 0.
  - cmd_ready = 1, since it is decoded from IDLE.
- States: IDLE, LOAD, DUMP_RD, DUMP_OUT, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid&cmd_ready: latch addr=cmd_base and rem=cmd_count.
  - If count == 0, go to DONE. Otherwise go to LOAD (op 0) or DUMP_RD (op 1).
- LOAD:
  - in_ready = 1.
  - On in_valid at posedge, register rf_we=1, rf_dir_wr=addr, rf_di=in_data for exactly one cycle. The file commits on the following negedge, so write latency is half a cycle after the registered strobe.
  - On each accepted word: addr += 1 mod 2**ADDR_W, rem -= 1.
  - When the last word is accepted, go to DONE; in_ready is 0 from the next cycle.
  - in_valid low means no write: rf_we = 0 and counters hold.
- DUMP_RD:
  - rf_dir_a = addr, registered, so it is stable for the whole cycle.
  - At posedge, capture rf_data_a into out_data, set out_valid = 1, go to DUMP_OUT.
- DUMP_OUT:
  - out_valid and out_data hold until out_ready.
  - On out_valid&out_ready: out_valid = 0, addr += 1 mod depth, rem -= 1.
  - Then go to DUMP_RD if rem != 0, else DONE.
  - Throughput: one word per 2 cycles minimum.
- DONE: done = 1 for one cycle, then IDLE. cmd_ready = 0 in DONE.
- Address wrap: base 14, count 4 touches registers 14, 15, 0, 1.
- count > 2**ADDR_W: rewrites/rereads wrap; no error is raised.
- cmd_valid outside IDLE is ignored (cmd_ready = 0); stream handshakes outside their own state are ignored (ready = 0).
- Read-after-write: a DUMP after a LOAD cannot start before DONE→IDLE, so the last write has already committed.
- Reset mid-operation: immediately return to IDLE with all outputs at reset values. Words already written stay in the register file; no completion pulse is issued.

Optional Feature:
- Macro: RF_STREAM_CHECKSUM_EN.
- Defined:
  - DUMP accumulates a DATA_W-bit wrapping sum of the words emitted.
  - After the last data word, the block emits one extra beat out_data = sum through a DUMP_SUM state with the same valid/ready rules; done follows that beat.
  - LOAD is unchanged.
- Undefined: no sum logic; DUMP emits exactly count beats.

Test Plan:
- Reset: assert rst_n=0 mid-LOAD after 2 of 4 words → rf_we=0, busy=0, cmd_ready=1 asynchronously; regs 3,4 hold the written values, regs 5,6 are untouched.
- LOAD: base 3, count 3, in_data 0x11,0x22,0x33 with in_valid gapped every other cycle → exactly 3 rf_we pulses at dir 3,4,5; single done pulse; in_ready=0 afterwards.
- DUMP with backpressure: after the LOAD above, DUMP base 3, count 3, out_ready low for 3 cycles on the 2nd beat → out_data 0x11,0x22,0x33 in order, with the 2nd beat held stable while stalled.
- Wrap: LOAD base 14, count 4, data 0xA..0xD → regs 14,15,0,1 written; DUMP base 14, count 4 returns 0xA,0xB,0xC,0xD.
- Count 0 and busy: cmd count 0 → done one cycle after accept, no rf_we, no out_valid; a cmd_valid issued during a busy DUMP is not accepted.
- Checksum (RF_STREAM_CHECKSUM_EN): DUMP of 0xFFFFFFFF, 0x00000002 → third beat 0x00000001, then done.
